// File: rtl/i2s_tx_64x.sv
// I2S master transmitter, 64 bclk per stereo frame (32 slots per channel).
// Sample pairs enter a 1-deep holding register over valid/ready and are
// copied into the active registers at each frame boundary. Everything is
// clocked on posedge bclk. The only combinational output is in_ready.
module i2s_tx_64x #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic [DATA_WIDTH-1:0] in_right,
  output logic                  lrclk,
  output logic                  sdout,
  output logic                  frame_start,
  output logic                  underrun
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_reg, state_next;
  logic [5:0]            cnt_reg, cnt_next;
  logic [DATA_WIDTH-1:0] hold_l_reg, hold_l_next;
  logic [DATA_WIDTH-1:0] hold_r_reg, hold_r_next;
  logic                  hold_full_reg, hold_full_next;
  logic [DATA_WIDTH-1:0] active_l_reg, active_l_next;
  logic [DATA_WIDTH-1:0] active_r_reg, active_r_next;
  logic                  lrclk_reg, lrclk_next;
  logic                  sdout_reg, sdout_next;
  logic                  frame_start_reg, frame_start_next;
  logic                  underrun_reg, underrun_next;

  logic                  boundary;
  logic                  load;
  logic                  accept;
  logic                  advance;
  logic                  slot_bit;
  logic [31:0]           slot_l;
  logic [31:0]           slot_r;

  // While idle the counter is parked at 0, so an idle start and a running
  // wrap both arrive here as the c==0 boundary, and en decides either way.
  assign boundary = (cnt_reg == 6'd0);
  assign load     = boundary & en & hold_full_reg;
  assign in_ready = ~hold_full_reg | load;
  assign accept   = in_valid & in_ready;

  // Slot-indexed view of each active word: slot p carries bit DATA_WIDTH-p
  // for p in 1..DATA_WIDTH, and every other slot of the half-frame is 0.
  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_slot
      if (gi >= 1 && gi <= DATA_WIDTH) begin : g_data
        assign slot_l[gi] = active_l_reg[DATA_WIDTH-gi];
        assign slot_r[gi] = active_r_reg[DATA_WIDTH-gi];
      end else begin : g_pad
        assign slot_l[gi] = 1'b0;
        assign slot_r[gi] = 1'b0;
      end
    end
  endgenerate

  assign slot_bit = cnt_reg[5] ? slot_r[cnt_reg[4:0]] : slot_l[cnt_reg[4:0]];

  // Next-state logic: frame sequencing, serial output, boundary load, handshake.
  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    hold_l_next      = hold_l_reg;
    hold_r_next      = hold_r_reg;
    hold_full_next   = hold_full_reg;
    active_l_next    = active_l_reg;
    active_r_next    = active_r_reg;
    lrclk_next       = 1'b0;
    sdout_next       = 1'b0;
    frame_start_next = 1'b0;
    underrun_next    = 1'b0;
    advance          = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (en) begin
          state_next = ST_RUN;
          advance    = 1'b1;
        end
      end
      ST_RUN: begin
        // A frame in flight always completes; en is only looked at on c==0.
        if (boundary && !en) begin
          state_next = ST_IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (advance) begin
      lrclk_next = ~cnt_reg[5];
      sdout_next = slot_bit;
      cnt_next   = cnt_reg + 6'd1;
      if (boundary) begin
        frame_start_next = 1'b1;
        if (hold_full_reg) begin
          active_l_next = hold_l_reg;
          active_r_next = hold_r_reg;
        end else begin
          // Nothing queued: transmit silence for the whole frame.
          active_l_next = '0;
          active_r_next = '0;
          underrun_next = 1'b1;
        end
      end
    end else begin
      cnt_next = 6'd0;
    end

    // Accept after load so a same-cycle load+accept leaves hold_full set
    // with the new pair while the active regs took the old one.
    if (load) begin
      hold_full_next = 1'b0;
    end
    if (accept) begin
      hold_l_next    = in_left;
      hold_r_next    = in_right;
      hold_full_next = 1'b1;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge bclk) begin
    if (!rst) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= 6'd0;
      hold_l_reg      <= '0;
      hold_r_reg      <= '0;
      hold_full_reg   <= 1'b0;
      active_l_reg    <= '0;
      active_r_reg    <= '0;
      lrclk_reg       <= 1'b0;
      sdout_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
      underrun_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      hold_l_reg      <= hold_l_next;
      hold_r_reg      <= hold_r_next;
      hold_full_reg   <= hold_full_next;
      active_l_reg    <= active_l_next;
      active_r_reg    <= active_r_next;
      lrclk_reg       <= lrclk_next;
      sdout_reg       <= sdout_next;
      frame_start_reg <= frame_start_next;
      underrun_reg    <= underrun_next;
    end
  end

  assign lrclk       = lrclk_reg;
  assign sdout       = sdout_reg;
  assign frame_start = frame_start_reg;
  assign underrun    = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_64x.sv
// Testbench for i2s_tx_64x: a 64x I2S receiver model decodes lrclk/sdout,
// and a monitor compares decoded frames and frame_start/underrun pulses
// against expectations queued by the directed stimulus.
module tb_i2s_tx_64x;
  localparam int DW = 16;

  logic          bclk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_left = '0;
  logic [DW-1:0] in_right = '0;
  logic          lrclk;
  logic          sdout;
  logic          frame_start;
  logic          underrun;

  i2s_tx_64x #(.DATA_WIDTH(DW)) dut (
    .bclk        (bclk),
    .rst         (rst),
    .en          (en),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_left     (in_left),
    .in_right    (in_right),
    .lrclk       (lrclk),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  always #5 bclk = ~bclk;

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] data_q[$];
  logic            evt_q[$];

  int          slot = 1000;
  int          rx_frames = 0;
  int          stray = 0;
  logic        prev_lr = 1'b0;
  logic        gap_ok = 1'b1;
  logic [DW-1:0] rx_l = '0;
  logic [DW-1:0] rx_r = '0;
  logic [2*DW-1:0] exp_pair;
  logic        exp_ur;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Receiver model and scoreboard monitor, sampling on the falling edge.
  always @(negedge bclk) begin
    if (!rst) begin
      slot    = 1000;
      prev_lr = 1'b0;
    end else begin
      if (lrclk && !prev_lr) begin
        if (gap_ok) check("lr_period_gap", longint'(slot >= 63), 1);
        else        check("lr_period", slot, 63);
        gap_ok = 1'b0;
        slot   = 0;
        rx_l   = '0;
        rx_r   = '0;
        stray  = 0;
        rx_frames++;
      end else if (slot < 1000) begin
        slot++;
      end
      if (!lrclk && prev_lr) check("lr_fall_slot", slot, 32);
      if (slot >= 1 && slot <= DW)            rx_l = {rx_l[DW-2:0], sdout};
      else if (slot >= 33 && slot <= 32 + DW) rx_r = {rx_r[DW-2:0], sdout};
      else if (slot < 64)                     stray = stray + int'(sdout);
      else if (slot < 1000)                   check("idle_sdout", longint'(sdout), 0);
      if (slot == 63) begin
        if (data_q.size() == 0) begin
          check("rx_unexpected_frame", 1, 0);
        end else begin
          exp_pair = data_q.pop_front();
          check("rx_left", rx_l, exp_pair[2*DW-1:DW]);
          check("rx_right", rx_r, exp_pair[DW-1:0]);
          $display("frame %0d: L=%h R=%h expected L=%h R=%h", rx_frames, rx_l, rx_r,
                   exp_pair[2*DW-1:DW], exp_pair[DW-1:0]);
        end
        check("rx_stray_bits", stray, 0);
      end
      if (frame_start) begin
        check("fs_slot", slot, 0);
        if (evt_q.size() == 0) begin
          check("fs_unexpected", 1, 0);
        end else begin
          exp_ur = evt_q.pop_front();
          check("underrun_flag", longint'(underrun), longint'(exp_ur));
        end
      end else if (underrun) begin
        check("underrun_without_fs", longint'(underrun), 0);
      end
      prev_lr = lrclk;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge bclk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic push);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_left  = l;
    in_right = r;
    #1;
    while (!in_ready && n < 200) begin
      @(posedge bclk);
      #1;
      n++;
    end
    if (n >= 200) check("send_timeout", 1, 0);
    @(posedge bclk);
    #1;
    in_valid = 1'b0;
    if (push) data_q.push_back({l, r});
  endtask

  task automatic wait_slot(input int frame, input int s);
    int n;
    n = 0;
    while (!(rx_frames == frame && slot == s) && n < 5000) begin
      @(posedge bclk);
      #1;
      n++;
    end
    if (n >= 5000) check("wait_slot_timeout", 1, 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_lrclk"}, longint'(lrclk), 0);
    check({tag, "_sdout"}, longint'(sdout), 0);
    check({tag, "_frame_start"}, longint'(frame_start), 0);
    check({tag, "_underrun"}, longint'(underrun), 0);
  endtask

  logic [DW-1:0] bp_l[3] = '{16'h5555, 16'h0FF0, 16'h8001};
  logic [DW-1:0] bp_r[3] = '{16'hAAAA, 16'hF00F, 16'h7FFE};

  initial begin
    int waits;
    int n;

    // Reset state.
    repeat (3) @(posedge bclk);
    #1;
    check_idle_outputs("reset");
    check("reset_in_ready", longint'(in_ready), 1);
    rst = 1'b1;
    tick(2);

    // Single preloaded pair, then loopback stream with no underrun.
    send(16'hA5C3, 16'h0F01, 1'b1);
    repeat (4) evt_q.push_back(1'b0);
    en = 1'b1;
    tick(1);
    check("start_lrclk", longint'(lrclk), 1);
    check("start_frame_start", longint'(frame_start), 1);
    check("start_sdout_slot0", longint'(sdout), 0);
    send(16'h8000, 16'h7FFF, 1'b1);
    send(16'h0001, 16'hFFFF, 1'b1);
    send(16'h1234, 16'hFEDC, 1'b1);

    // Starvation: frames 5..8 carry silence and pulse underrun.
    repeat (4) begin
      evt_q.push_back(1'b1);
      data_q.push_back('0);
    end

    // en dropped mid-frame 8: frame completes, then idle.
    wait_slot(8, 20);
    en     = 1'b0;
    gap_ok = 1'b1;
    wait_slot(8, 80);
    check_idle_outputs("en_off_idle");
    tick(40);

    // Backpressure: in_valid held high, one accept per frame at c==0.
    send(16'hC001, 16'h3FFE, 1'b1);
    repeat (4) evt_q.push_back(1'b0);
    evt_q.push_back(1'b1);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_left  = bp_l[k];
      in_right = bp_r[k];
      #1;
      waits = 0;
      while (!in_ready && waits < 200) begin
        @(posedge bclk);
        #1;
        waits++;
      end
      if (waits >= 200) check("bp_timeout", 1, 0);
      @(posedge bclk);
      #1;
      check("bp_accept_at_boundary", longint'(frame_start), 1);
      if (k > 0) check("bp_ready_low_cycles", waits, 63);
      data_q.push_back({bp_l[k], bp_r[k]});
    end
    in_valid = 1'b0;

    // Mid-frame reset with a pair sitting in hold; it must be discarded.
    wait_slot(13, 5);
    send(16'hDEAD, 16'hBEEF, 1'b0);
    wait_slot(13, 40);
    rst    = 1'b0;
    en     = 1'b0;
    gap_ok = 1'b1;
    tick(1);
    check_idle_outputs("midreset");
    check("midreset_in_ready", longint'(in_ready), 1);
    tick(2);
    rst = 1'b1;
    tick(2);

    // Fresh start: first frame underruns, second carries the new pair.
    evt_q.push_back(1'b1);
    data_q.push_back('0);
    evt_q.push_back(1'b0);
    en = 1'b1;
    tick(2);
    check("restart_lrclk", longint'(lrclk), 1);
    send(16'h6B3D, 16'h1C2E, 1'b1);
    wait_slot(15, 10);
    en     = 1'b0;
    gap_ok = 1'b1;

    n = 0;
    while ((data_q.size() != 0 || evt_q.size() != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    tick(10);
    check("drain_data", data_q.size(), 0);
    check("drain_evt", evt_q.size(), 0);
    check("final_lrclk", longint'(lrclk), 0);
    check("final_sdout", longint'(sdout), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2s_tx_64x.md
Name: i2s_tx_64x

Overview:
- I2S master transmitter, 64 bclk per stereo frame (32 slots per channel). It is the transmit-side counterpart of the 64x I2S receiver.
- Generates lrclk and sdout from bclk. Accepts stereo sample pairs through a valid/ready handshake into a 1-deep holding register.
- Sits between the DSP/decimation output and the board DAC or codec. Loopback into the 64x receiver must return identical samples.

Parameters:
- DATA_WIDTH, 16, bits per channel sample; legal range 2..31.

Ports:
- bclk  in  1  bit clock (3.072 MHz); the only clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-low (asserted when 0).
- en  in  1  frame enable; sampled only at frame boundary.
- in_valid  in  1  stereo pair offered.
- in_ready  out  1  holding register can accept this cycle.
- in_left  in  DATA_WIDTH  left sample, two's complement.
- in_right  in  DATA_WIDTH  right sample.
- lrclk  out  1  word select; 1 = left slot, 0 = right slot.
- sdout  out  1  serial data, MSB first.
- frame_start  out  1  one-cycle pulse when a frame begins (active pair loaded).
- underrun  out  1  one-cycle pulse when a frame began with the holding register empty.

Behaviour:
- Reset (rst==0 at posedge):
  - cnt=0, running=0, hold_full=0, hold and active regs=0.
  - lrclk=0, sdout=0, frame_start=0, underrun=0.
  - in_ready=1 combinationally after reset.
- Frame counter cnt[5:0] advances 0..63 and wraps to 0 while running.
- Idle (running==0):
  - cnt held at 0; lrclk=0, sdout=0.
  - At any posedge with en==1, the frame starts: that posedge is treated as cnt==0 processing below, and running is set to 1.
- Per posedge while processing count value c:
  - lrclk <= (c<32).
  - Let p = c mod 32. sdout <= word[DATA_WIDTH-p] for 1<=p<=DATA_WIDTH, else 0. word is active_l when c<32, active_r otherwise.
  - cnt <= c+1 (wraps 63->0).
- Result: MSB appears one bclk after each lrclk edge. A receiver sampling on the following posedge captures slots 1..DATA_WIDTH as MSB..LSB.
- Frame boundary (c==0):
  - If hold_full: active_l/active_r <= hold; hold_full cleared; frame_start=1.
  - Else: active <= 0 (transmit silence); frame_start=1; underrun=1.
  - If en==0 at c==0: running <= 0, no load, outputs return to idle values. The frame in progress always completes; no mid-frame abort.
- Handshake:
  - in_ready = !hold_full || load_this_cycle. A combinational ready path is permitted; it is the only combinational output.
  - Transfer when in_valid && in_ready at a posedge: hold <= {in_left,in_right}, hold_full <= 1.
  - Simultaneous load and accept at c==0: the active regs take the old hold value and hold takes the new pair. hold_full stays 1.
  - in_left/in_right are don't-care when in_valid==0.
- Active regs are stable for the whole 64-cycle frame; changes to hold never affect the frame in flight.
- Reset mid-frame: immediate return to reset state on that posedge. Any partial word is discarded.
- Frame period: exactly 64 bclk; lrclk duty exactly 32/32.

Test Plan:
- Reset then en=1, one pair L=16'hA5C3, R=16'h0F01 preloaded:
  - lrclk rises at the 1st posedge and falls 32 cycles later.
  - sdout slots 1..16 = 1010_0101_1100_0011; right slots 33..48 = 0000_1111_0000_0001.
  - All other slots are 0.
  - frame_start pulses once, underrun stays 0.
- Loopback into the 64x receiver, pairs (16'h8000,16'h7FFF), (16'h0001,16'hFFFF), (16'h1234,16'hFEDC) streamed back-to-back:
  - The receiver reports identical left/right values in order.
  - No underrun pulses.
- No data offered for 3 frames after start:
  - underrun pulses at cycles 0, 64 and 128.
  - sdout is constant 0; lrclk keeps toggling every 32 cycles.
- Handshake backpressure, in_valid held high with a new pair each accepted beat:
  - in_ready is low from the accept until frame boundary c==0, then high in that cycle.
  - Exactly one pair is accepted per frame and none are lost or duplicated.
- en deasserted at cycle 20 of a frame:
  - The frame completes to cycle 63, then lrclk=0, sdout=0, cnt=0.
  - No further frame_start until en returns to 1.
- rst=0 asserted at cycle 40 mid right-word:
  - On the next posedge all outputs go to 0, hold_full=0 and in_ready=1.
  - After release and en=1, a fresh frame starts with correct alignment.
